// File: rtl/multi_debouncer.sv
// Multi-channel key debouncer: per-channel synchroniser, 4-state FSM and tick counters
// producing a debounced level plus press, release and one-shot long-press strobes.
module multi_debouncer #(
  parameter int WIDTH      = 1,
  parameter int DEB_TICKS  = 20,
  parameter int LONG_TICKS = 1000,
  parameter int CNT_BITS   = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pulse1kHz,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] press,
  output logic [WIDTH-1:0] release_strobe,
  output logic [WIDTH-1:0] long_press
);

  typedef enum logic [1:0] {
    ST_LOW   = 2'd0,
    ST_CHK_H = 2'd1,
    ST_HIGH  = 2'd2,
    ST_CHK_L = 2'd3
  } state_t;

  localparam logic [CNT_BITS-1:0] CNT_ONE   = CNT_BITS'(1);
  localparam logic [CNT_BITS-1:0] DEB_LAST  = CNT_BITS'(DEB_TICKS - 1);
  localparam logic [CNT_BITS-1:0] LONG_MAX  = CNT_BITS'(LONG_TICKS);
  localparam logic [CNT_BITS-1:0] LONG_LAST = CNT_BITS'((LONG_TICKS > 0) ? LONG_TICKS - 1 : 0);
  localparam bit                  LONG_EN   = (LONG_TICKS != 0);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_ch
      logic [1:0]          sync_reg;
      logic                in_s;
      state_t              state_reg, state_next;
      logic [CNT_BITS-1:0] dcnt_reg, dcnt_next;
      logic [CNT_BITS-1:0] hcnt_reg, hcnt_next;
      logic                press_reg, press_next;
      logic                rel_reg, rel_next;
      logic                long_reg, long_next;

      assign in_s = sync_reg[1];

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          sync_reg  <= 2'b00;
          state_reg <= ST_LOW;
          dcnt_reg  <= '0;
          hcnt_reg  <= '0;
          press_reg <= 1'b0;
          rel_reg   <= 1'b0;
          long_reg  <= 1'b0;
        end else begin
          sync_reg  <= {sync_reg[0], in[gi]};
          state_reg <= state_next;
          dcnt_reg  <= dcnt_next;
          hcnt_reg  <= hcnt_next;
          press_reg <= press_next;
          rel_reg   <= rel_next;
          long_reg  <= long_next;
        end
      end

      // A level change on in_s takes priority over a coincident tick.
      always_comb begin
        state_next = state_reg;
        dcnt_next  = dcnt_reg;
        hcnt_next  = hcnt_reg;
        press_next = 1'b0;
        rel_next   = 1'b0;
        long_next  = 1'b0;
        unique case (state_reg)
          ST_LOW: begin
            if (in_s) begin
              state_next = ST_CHK_H;
              dcnt_next  = '0;
            end
          end
          ST_CHK_H: begin
            if (!in_s) begin
              state_next = ST_LOW;
            end else if (pulse1kHz) begin
              if (dcnt_reg == DEB_LAST) begin
                state_next = ST_HIGH;
                hcnt_next  = '0;
                press_next = 1'b1;
              end else begin
                dcnt_next = dcnt_reg + CNT_ONE;
              end
            end
          end
          ST_HIGH: begin
            if (!in_s) begin
              state_next = ST_CHK_L;
              dcnt_next  = '0;
            end else if (pulse1kHz && LONG_EN && (hcnt_reg < LONG_MAX)) begin
              hcnt_next = hcnt_reg + CNT_ONE;
              long_next = (hcnt_reg == LONG_LAST);
            end
          end
          ST_CHK_L: begin
            // hcnt is left alone so a short dropout cannot re-arm long_press.
            if (in_s) begin
              state_next = ST_HIGH;
            end else if (pulse1kHz) begin
              if (dcnt_reg == DEB_LAST) begin
                state_next = ST_LOW;
                rel_next   = 1'b1;
              end else begin
                dcnt_next = dcnt_reg + CNT_ONE;
              end
            end
          end
          default: state_next = ST_LOW;
        endcase
      end

      assign out[gi]            = (state_reg == ST_HIGH) || (state_reg == ST_CHK_L);
      assign press[gi]          = press_reg;
      assign release_strobe[gi] = rel_reg;
      assign long_press[gi]     = long_reg;
    end
  endgenerate

endmodule

// File: tb/tb_multi_debouncer.sv
// Scoreboard bench for multi_debouncer: stimulus pushes expected strobe events (tick index
// plus output vectors); monitors pop and compare whenever a DUT raises any strobe.
module tb_multi_debouncer;
  localparam int W = 4;

  typedef struct {
    int         tk;
    logic [W-1:0] p;
    logic [W-1:0] r;
    logic [W-1:0] l;
    logic [W-1:0] o;
  } ev_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         pulse1kHz;
  logic [W-1:0] in;
  logic [W-1:0] out, press, rel, lp;
  logic [W-1:0] out_nl, press_nl, rel_nl, lp_nl;

  int           checks = 0;
  int           errors = 0;
  int           tick_cnt = 0;
  int           phase = 0;
  int           t;
  logic [W-1:0] nl_long_seen = '0;
  ev_t          q_main[$];
  ev_t          q_nl[$];
  ev_t          em, en;

  always #5 clk = ~clk;

  multi_debouncer #(.WIDTH(W), .DEB_TICKS(3), .LONG_TICKS(5), .CNT_BITS(4)) u_dut (
    .clk(clk), .reset(reset), .pulse1kHz(pulse1kHz), .in(in),
    .out(out), .press(press), .release_strobe(rel), .long_press(lp)
  );

  multi_debouncer #(.WIDTH(W), .DEB_TICKS(3), .LONG_TICKS(0), .CNT_BITS(4)) u_dut_nl (
    .clk(clk), .reset(reset), .pulse1kHz(pulse1kHz), .in(in),
    .out(out_nl), .press(press_nl), .release_strobe(rel_nl), .long_press(lp_nl)
  );

  // Tick every 4 clk; tick_cnt counts ticks the DUT has sampled.
  initial begin
    pulse1kHz = 1'b0;
    forever begin
      @(negedge clk);
      pulse1kHz = (phase == 3);
      phase = (phase + 1) % 4;
    end
  end

  initial forever begin
    @(posedge clk);
    if (pulse1kHz) tick_cnt++;
  end

  task automatic wait_ticks(input int n);
    int target;
    target = tick_cnt + n;
    while (tick_cnt < target) @(negedge clk);
  endtask

  task automatic expect_ev(input int tk, input logic [W-1:0] p, input logic [W-1:0] r,
                           input logic [W-1:0] l, input logic [W-1:0] o);
    ev_t e;
    e.tk = tk; e.p = p; e.r = r; e.l = l; e.o = o;
    q_main.push_back(e);
    if ((p | r) != '0) begin
      e.l = '0;
      q_nl.push_back(e);
    end
  endtask

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%b want=%b", nm, act, exp);
    end else begin
      $display("ok   %s = %b", nm, act);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end else begin
      $display("ok   %s = %0d", nm, act);
    end
  endtask

  // Monitor: main DUT (LONG_TICKS=5)
  initial forever begin
    @(posedge clk);
    #1;
    if ((press | rel | lp) != '0) begin
      checks++;
      if (q_main.size() == 0) begin
        errors++;
        $display("FAIL main_unexpected tick=%0d press=%b release=%b long=%b out=%b",
                 tick_cnt, press, rel, lp, out);
      end else begin
        em = q_main.pop_front();
        if (em.tk != tick_cnt || em.p !== press || em.r !== rel || em.l !== lp || em.o !== out) begin
          errors++;
          $display("FAIL main_event got tick=%0d p=%b r=%b l=%b o=%b want tick=%0d p=%b r=%b l=%b o=%b",
                   tick_cnt, press, rel, lp, out, em.tk, em.p, em.r, em.l, em.o);
        end else begin
          $display("ok   main_event tick=%0d p=%b r=%b l=%b o=%b", tick_cnt, press, rel, lp, out);
        end
      end
    end
  end

  // Monitor: LONG_TICKS=0 DUT
  initial forever begin
    @(posedge clk);
    #1;
    nl_long_seen = nl_long_seen | lp_nl;
    if ((press_nl | rel_nl | lp_nl) != '0) begin
      checks++;
      if (q_nl.size() == 0) begin
        errors++;
        $display("FAIL nl_unexpected tick=%0d press=%b release=%b long=%b out=%b",
                 tick_cnt, press_nl, rel_nl, lp_nl, out_nl);
      end else begin
        en = q_nl.pop_front();
        if (en.tk != tick_cnt || en.p !== press_nl || en.r !== rel_nl || en.l !== lp_nl || en.o !== out_nl) begin
          errors++;
          $display("FAIL nl_event got tick=%0d p=%b r=%b l=%b o=%b want tick=%0d p=%b r=%b l=%b o=%b",
                   tick_cnt, press_nl, rel_nl, lp_nl, out_nl, en.tk, en.p, en.r, en.l, en.o);
        end else begin
          $display("ok   nl_event tick=%0d p=%b r=%b l=%b o=%b", tick_cnt, press_nl, rel_nl, lp_nl, out_nl);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at tick=%0d", tick_cnt);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    in    = '0;
    repeat (3) @(negedge clk);
    chk("reset_out", out, '0);
    chk("reset_press", press, '0);
    chk("reset_release", rel, '0);
    chk("reset_long", lp, '0);
    reset = 1'b1;
    wait_ticks(1);

    // Clean press on ch0, held 10 ticks after acceptance
    t = tick_cnt; in = 4'b0001;
    expect_ev(t + 3, 4'b0001, '0, '0, 4'b0001);
    expect_ev(t + 8, '0, '0, 4'b0001, 4'b0001);
    wait_ticks(13);
    t = tick_cnt; in = '0;
    expect_ev(t + 3, '0, 4'b0001, '0, '0);
    wait_ticks(5);

    // Bounce on ch1, then a clean 3-tick high and clean low
    in = 4'b0010; wait_ticks(2);
    in = '0;      wait_ticks(1);
    in = 4'b0010; wait_ticks(2);
    in = '0;      wait_ticks(4);
    chk("bounce_out", out, '0);
    t = tick_cnt; in = 4'b0010;
    expect_ev(t + 3, 4'b0010, '0, '0, 4'b0010);
    wait_ticks(3);
    t = tick_cnt; in = '0;
    expect_ev(t + 3, '0, 4'b0010, '0, '0);
    wait_ticks(4);

    // Release glitch on ch2 at hcnt=3; long_press after 5 total HIGH ticks
    t = tick_cnt; in = 4'b0100;
    expect_ev(t + 3, 4'b0100, '0, '0, 4'b0100);
    expect_ev(t + 9, '0, '0, 4'b0100, 4'b0100);
    wait_ticks(6);
    in = '0;      wait_ticks(1);
    in = 4'b0100; wait_ticks(6);
    t = tick_cnt; in = '0;
    expect_ev(t + 3, '0, 4'b0100, '0, '0);
    wait_ticks(4);

    // ch3 and ch0 together
    t = tick_cnt; in = 4'b1001;
    expect_ev(t + 3, 4'b1001, '0, '0, 4'b1001);
    expect_ev(t + 8, '0, '0, 4'b1001, 4'b1001);
    wait_ticks(9);
    t = tick_cnt; in = '0;
    expect_ev(t + 3, '0, 4'b1001, '0, '0);
    wait_ticks(4);

    // ch3 drop lands on the would-be accepting tick: abort wins, no press
    in = 4'b1000; wait_ticks(2);
    @(negedge clk);
    in = '0;
    wait_ticks(4);
    chk("abort_out", out, '0);

    // Async reset with ch0 in HIGH and ch1 in CHK_H
    t = tick_cnt; in = 4'b0001;
    expect_ev(t + 3, 4'b0001, '0, '0, 4'b0001);
    wait_ticks(4);
    in = 4'b0011;
    wait_ticks(1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_out", out, '0);
    chk("async_rst_press", press, '0);
    chk("async_rst_release", rel, '0);
    chk("async_rst_long", lp, '0);
    chk("async_rst_out_nl", out_nl, '0);
    in = 4'b1111;
    repeat (3) @(negedge clk);
    wait_ticks(1);
    reset = 1'b1;
    t = tick_cnt;
    expect_ev(t + 3, 4'b1111, '0, '0, 4'b1111);
    expect_ev(t + 8, '0, '0, 4'b1111, 4'b1111);
    wait_ticks(9);
    t = tick_cnt; in = '0;
    expect_ev(t + 3, '0, 4'b1111, '0, '0);
    wait_ticks(4);

    // 20-tick hold on ch0: main fires long once, LONG_TICKS=0 instance never does
    t = tick_cnt; in = 4'b0001;
    expect_ev(t + 3, 4'b0001, '0, '0, 4'b0001);
    expect_ev(t + 8, '0, '0, 4'b0001, 4'b0001);
    wait_ticks(23);
    t = tick_cnt; in = '0;
    expect_ev(t + 3, '0, 4'b0001, '0, '0);
    wait_ticks(5);

    chk_int("main_queue_left", q_main.size(), 0);
    chk_int("nl_queue_left", q_nl.size(), 0);
    chk("nl_long_never", nl_long_seen, '0);
    chk("final_out", out, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_debouncer.md
# multi_debouncer

Parametrised multi-channel key debouncer, the successor to the single-timer debouncer. Each channel has its own synchroniser, state machine and tick counters, so channels settle independently. Each channel provides a debounced level, one-clock press and release strobes, and a one-shot long-press strobe. It sits between raw key/switch pins and the control FSMs, paced by the shared 1 kHz tick.

## Interface
- WIDTH, 1: number of independent channels.
- DEB_TICKS, 20: ticks a new level must stay stable before it is accepted (≥1).
- LONG_TICKS, 1000: ticks of accepted-high hold before long_press fires; 0 disables long_press.
- CNT_BITS, 10: counter width; DEB_TICKS and LONG_TICKS must be < 2^CNT_BITS.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- pulse1kHz  in  1  one-clk-wide tick enable, 1 kHz.
- in  in  WIDTH  raw asynchronous inputs, active-high.
- out  out  WIDTH  debounced level.
- press  out  WIDTH  one-clk strobe, debounced rising edge.
- release  out  WIDTH  one-clk strobe, debounced falling edge.
- long_press  out  WIDTH  one-clk strobe, hold reached LONG_TICKS.

## Operation
- Per channel, a 2-flop synchroniser produces in_s. The FSM acts only on in_s.
- Per channel, dcnt counts debounce ticks and hcnt counts hold ticks. Both are CNT_BITS wide.
- FSM states: LOW, CHK_H, HIGH, CHK_L. out is 1 in HIGH and CHK_L, and 0 otherwise.
- LOW: if in_s=1, go to CHK_H and clear dcnt.
- CHK_H:
  - in_s=0: return to LOW with no strobe (bounce rejected).
  - in_s=1 and tick: if dcnt = DEB_TICKS-1, go to HIGH, clear hcnt and pulse press. Otherwise increment dcnt.
- HIGH:
  - in_s=0: go to CHK_L and clear dcnt.
  - in_s=1 and tick and LONG_TICKS≠0: increment hcnt, saturating at LONG_TICKS. On the tick where hcnt goes LONG_TICKS-1 → LONG_TICKS, pulse long_press exactly once per press.
- CHK_L:
  - in_s=1: return to HIGH with no strobe. hcnt is preserved, so a glitch does not re-arm long_press.
  - in_s=0 and tick: if dcnt = DEB_TICKS-1, go to LOW and pulse release. Otherwise increment dcnt.
- Input change versus tick in the same clk: the in_s comparison wins (abort or transition) and the tick is not counted.
- Channels are fully independent. Simultaneous events on different channels each produce their own strobes in the same clk.
- Strobes are registered and coincide with the first clk of the new out value. long_press and press are never asserted in the same clk.

## Timing
- Reset (reset=0), asynchronous: all FSMs go to LOW, and synchroniser flops, dcnt, hcnt, out, press, release and long_press all go to 0.
- Reset release with in held at 1: the channel is treated as a fresh press and needs a full debounce. There is no power-on press bypass.
- Reset mid-debounce or mid-hold: all progress is discarded and no strobe is emitted.
- Press latency: 2 clk (synchroniser) + 1 clk (LOW→CHK_H), then DEB_TICKS ticks. out/press assert in the clk after the DEB_TICKS-th tick is sampled.
- Release latency: symmetric to press latency.
- Long press: long_press fires LONG_TICKS ticks after entry to HIGH, excluding ticks spent in CHK_L.
- Strobe width: exactly 1 clk regardless of tick rate.
- Counter arithmetic is unsigned with no wrap. dcnt never exceeds DEB_TICKS-1. hcnt saturates at LONG_TICKS.

## Test plan
Bench uses WIDTH=4, DEB_TICKS=3, LONG_TICKS=5, CNT_BITS=4, with a tick every 4 clk.
- Clean press on in[0], held 10 ticks → out[0] rises 3 ticks after in_s rises; press[0] is 1 clk; long_press[0] fires once, 5 ticks after out rises; other channels stay 0.
- Bounce on in[1] (high 2 ticks, low, high 2 ticks, low) → out[1] stays 0 with no strobes. Then a clean low of ≥3 ticks after a 3-tick high gives exactly one press and one release.
- Release glitch: in[2] accepted high, hcnt=3, then 1-tick low, then high again → no release, and long_press[2] fires when the total high hold reaches 5 ticks, once.
- in[3] and in[0] rise in the same clk → press[3] and press[0] assert in the same clk. Later, a tick coincident with an in[3] drop in CHK_H aborts to LOW and the tick is not counted.
- reset=0 asserted mid-CHK_H and mid-HIGH (asynchronously, between clk edges) → all outputs 0 immediately. After release with in=4'b1111 held, all four press strobes appear together after a full 3-tick debounce.
- LONG_TICKS=0 variant: hold for 20 ticks → long_press is never asserted; press/release behave as in the clean-press case.
